// File: rtl/piso_serializer_if.sv
// Bundle of the word handshake and serial output signals of piso_serializer.
// Handshake: a word moves from master to slave on a rising clk edge where
// in_valid && in_ready are both high; in_data is only looked at on that edge,
// and a master that raised in_valid keeps in_valid and in_data steady until it
// sees that edge.
interface piso_serializer_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             sout_first;
   logic             sout_last;
   logic             busy;

   modport master (
      output in_valid, in_data, shift_en,
      input  in_ready, sout, sout_valid, sout_first, sout_last, busy
   );

   modport slave (
      input  in_valid, in_data, shift_en,
      output in_ready, sout, sout_valid, sout_first, sout_last, busy
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: takes a WIDTH-bit word over a valid/ready
// handshake and sends it one bit per enabled clock with first/last strobes.
// Back-to-back words follow each other with no idle cycle; shift_en = 0 freezes
// the serial stream. busy mirrors the FSM state (1 = SHIFT).
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   piso_serializer_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sout_q, sout_d;
   logic             valid_q, valid_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             at_last;
   logic             advance;
   logic             accept;

   // A stalled word (shift_en = 0) blocks new words even on its last bit.
   assign at_last      = (cnt_q == LAST);
   assign advance      = (state_q == SHIFT) && bus.shift_en;
   assign bus.in_ready = (state_q == IDLE) || (advance && at_last);
   assign accept       = bus.in_valid && bus.in_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave SHIFT only when the last bit moves on with no new word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SHIFT;
         SHIFT:   if (advance && at_last && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: load on accept, shift while advancing, hold on stall.
   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (accept) begin
         shreg_d = bus.in_data;
         cnt_d   = '0;
      end else if (advance && !at_last) begin
         shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
         cnt_d   = cnt_q + 1'b1;
      end else if (advance) begin
         cnt_d   = '0;
      end
      if (state_d == SHIFT) begin
         sout_d  = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
         valid_d = 1'b1;
         first_d = (cnt_d == '0);
         last_d  = (cnt_d == LAST);
      end else begin
         sout_d  = 1'b0;
         valid_d = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   // Datapath and registered serial outputs; reset drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         sout_q  <= 1'b0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign bus.sout       = sout_q;
   assign bus.sout_valid = valid_q;
   assign bus.sout_first = first_q;
   assign bus.sout_last  = last_q;
   assign bus.busy       = (state_q == SHIFT);
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer that accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with framing strobes. It is the transmit end of a serial link whose receive end is a shift-and-capture register feeding the existing parallel-load register path. It supports gap-free back-to-back words and a shift-enable stall.

## Interface
- WIDTH, 4, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a word to send
- in_data  input  WIDTH  parallel word; sampled only on handshake
- in_ready  output  1  block can accept a word this cycle (combinational from state and shift_en)
- shift_en  input  1  1 = advance serial stream this cycle, 0 = stall
- sout  output  1  serial data bit (registered)
- sout_valid  output  1  sout carries a valid bit (registered)
- sout_first  output  1  sout is the first bit of a word (registered)
- sout_last  output  1  sout is the last bit of a word (registered)
- busy  output  1  word in flight (state == SHIFT)

## Operation
- Single clock domain. One reset, rst_n, asynchronous assert and synchronous release.
- State machine has two states: IDLE and SHIFT. It also holds a WIDTH-bit shift register and a bit counter cnt of width clog2(WIDTH).
- Handshake: a word is accepted at a rising edge where in_valid && in_ready. in_data is ignored at all other times.
- in_ready = (IDLE) || (SHIFT && cnt == WIDTH-1 && shift_en).
- IDLE:
  - sout_valid = 0, sout = 0, first = 0, last = 0.
  - On accept: load the shift register from in_data, present the first bit, set cnt = 0, go to SHIFT.
- SHIFT with shift_en = 1, per edge:
  - If cnt < WIDTH-1: shift, present the next bit, cnt++.
  - If cnt == WIDTH-1 and a new word is accepted: reload and present its first bit with sout_first = 1, cnt = 0, stay in SHIFT. There is no idle gap between words.
  - If cnt == WIDTH-1 and no word is accepted: go to IDLE and clear sout_valid.
- SHIFT with shift_en = 0: all registers hold, including sout, sout_valid, sout_first, sout_last and cnt. in_ready = 0.
- shift_en has no effect in IDLE.
- Bit order: with MSB_FIRST = 1, bits go out in_data[WIDTH-1] down to [0]; otherwise [0] up to [WIDTH-1].
- sout_first = 1 exactly when cnt == 0 in SHIFT. sout_last = 1 exactly when cnt == WIDTH-1 in SHIFT.
- Reset (any time, including mid-word):
  - state = IDLE, cnt = 0, shift register = 0.
  - sout, sout_valid, sout_first and sout_last are all 0.
  - busy = 0, in_ready = 1.
  - The partial word is discarded; the next word starts fresh.

## Timing
- Latency: a word accepted at edge k has its first bit on sout from just after edge k. Bit i (0-based) is valid in the cycle after edge k+i, assuming no stalls.
- Word duration is WIDTH cycles plus the number of shift_en = 0 cycles.
- Sustained throughput is 1 bit per cycle with continuous in_valid and shift_en = 1.
- Outputs change only on a rising clk edge or on rst_n falling (asynchronous).
- in_valid asserted while in_ready = 0: no accept, no state change. The source must hold the word.
- Simultaneous last bit and shift_en = 0: no accept that cycle. The last bit is held until shift_en returns.

## Test plan
- Single word, WIDTH=4, MSB_FIRST=1, in_data=4'b1010 → sout = 1,0,1,0 on 4 consecutive cycles, sout_valid high for exactly 4 cycles, first on cycle 1, last on cycle 4, then IDLE with in_ready = 1.
- Back-to-back 4'b1010 then 4'b0101 with in_valid held high → 8 contiguous valid bits 1,0,1,0,0,1,0,1. sout_first is on bits 1 and 5, and in_ready pulses high in the bit-4 cycle.
- MSB_FIRST=0, in_data=4'b1100 → sout = 0,0,1,1.
- Stall: shift_en = 0 for 2 cycles after bit 2 of 4'b1010 → sout holds 0 for 3 cycles total and in_ready stays 0. The full sequence completes after 6 cycles.
- Busy rejection: in_valid = 1 with in_data=4'b1111 during bits 1-3 of a word → not accepted, and the first word is unchanged.
- Reset mid-word: rst_n low after bit 2, asynchronously between edges → all outputs 0 immediately. After release, 4'b0011 serializes as 0,0,1,1 with sout_first on bit 1.
